mem_wb_stage: RTL

Parametrised MEM/WB pipeline register, successor to the fixed 32-bit latch. It adds a valid/ready handshake, a 2-entry skid buffer for back-pressure, and a flush that inserts bubbles. It also selects the writeback data and exposes a forwarding tap for the hazard unit. It sits between the memory stage and the register-file write port.

---
 rtl/mem_wb_pkg.sv | 28 ++
 rtl/pipe_skid_buf.sv | 57 +++++
 rtl/mem_wb_stage.sv | 96 +++++++++
 3 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types and helpers for the MEM/WB pipeline register.
// The optional performance counters are enabled with MEM_WB_PERF_CNT_EN.
package mem_wb_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int ZERO_REG       = 0;

  typedef struct packed {
    logic                      regwrite;
    logic                      memtoreg;
    logic [DEF_DATA_W-1:0]     rdata;
    logic [DEF_DATA_W-1:0]     alu_res;
    logic [DEF_REG_ADDR_W-1:0] wreg;
  } mem_wb_entry_t;

  // Flat payload width for a given parameterisation; same field order as the struct.
  function automatic int entry_w(int dw, int aw);
    return 2 + 2 * dw + aw;
  endfunction

  function automatic logic [31:0] sat_add32(logic [31:0] a, logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush. The main entry drives the output;
// the skid entry catches one input while the consumer stalls, keeping in_ready registered.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         m_vld, s_vld;
  logic [W-1:0] m_dat, s_dat;
  logic         acc, drn;

  assign in_ready  = ~s_vld;
  assign out_valid = m_vld;
  assign out_data  = m_dat;
  assign acc       = in_valid & ~s_vld;
  assign drn       = m_vld & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_dat <= '0;
      s_dat <= '0;
    end else if (flush) begin
      // Payloads are left stale on purpose; only the valid bits matter.
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (!m_vld) begin
      if (acc) begin
        m_vld <= 1'b1;
        m_dat <= in_data;
      end
    end else if (drn) begin
      if (s_vld) begin
        m_dat <= s_dat;
        s_vld <= 1'b0;
      end else if (acc) begin
        m_dat <= in_data;
      end else begin
        m_vld <= 1'b0;
      end
    end else if (!s_vld && acc) begin
      s_vld <= 1'b1;
      s_dat <= in_data;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: skid-buffered handshake, writeback mux, forwarding tap.
// Define MEM_WB_PERF_CNT_EN to add the stall_cnt / flush_cnt counters.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int REG_ADDR_W    = 5,
  parameter bit ZERO_REG_GATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_regwrite,
  input  logic                  in_memtoreg,
  input  logic [DATA_W-1:0]     in_rdata,
  input  logic [DATA_W-1:0]     in_alu_res,
  input  logic [REG_ADDR_W-1:0] in_wreg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_wreg,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  fwd_en,
  output logic [REG_ADDR_W-1:0] fwd_wreg,
  output logic [DATA_W-1:0]     fwd_data
`ifdef MEM_WB_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  localparam int PAY_W = entry_w(DATA_W, REG_ADDR_W);

  logic [PAY_W-1:0]      in_pay, m_pay;
  logic                  m_regwrite, m_memtoreg, wreg_ok;
  logic [DATA_W-1:0]     m_rdata, m_alu_res;
  logic [REG_ADDR_W-1:0] m_wreg;

  assign in_pay = {in_regwrite, in_memtoreg, in_rdata, in_alu_res, in_wreg};

  pipe_skid_buf #(.W(PAY_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (m_pay)
  );

  assign m_regwrite = m_pay[PAY_W-1];
  assign m_memtoreg = m_pay[PAY_W-2];
  assign m_rdata    = m_pay[REG_ADDR_W+DATA_W +: DATA_W];
  assign m_alu_res  = m_pay[REG_ADDR_W +: DATA_W];
  assign m_wreg     = m_pay[REG_ADDR_W-1:0];

  generate
    if (ZERO_REG_GATE) begin : g_zgate
      assign wreg_ok = (m_wreg != REG_ADDR_W'(ZERO_REG));
    end else begin : g_nogate
      assign wreg_ok = 1'b1;
    end
  endgenerate

  // Mux sits after the register so the write port sees a stable selected value.
  assign wb_we    = out_valid & m_regwrite & wreg_ok;
  assign wb_wreg  = m_wreg;
  assign wb_data  = m_memtoreg ? m_rdata : m_alu_res;
  assign fwd_en   = wb_we;
  assign fwd_wreg = wb_wreg;
  assign fwd_data = wb_data;

`ifdef MEM_WB_PERF_CNT_EN
  // Skid occupancy is exactly ~in_ready, so the live count is out_valid + ~in_ready.
  logic [1:0] n_kill;
  assign n_kill = {1'b0, out_valid} + {1'b0, ~in_ready};

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready)
        stall_cnt <= sat_add32(stall_cnt, 2'd1);
      if (flush)
        flush_cnt <= sat_add32(flush_cnt, n_kill);
    end
  end
`endif

endmodule
